relm_adc_io: RTL and testbench

SPI master for the on-board ADC128S022 8-channel, 12-bit ADC. It replaces software bit-banging of the ADC pins with a hardware frame sequencer. It attaches to the ReLM processor as one push port (conversion command) and one pop port (result), and drives the four ADC pins directly. Each push runs one 16-SCLK frame. The captured sample is held in a one-entry result register until the processor pops it.

---
 rtl/relm_adc_io_pkg.sv | 33 +++
 rtl/relm_adc_io_if.sv | 16 +
 rtl/relm_adc_io_clkdiv.sv | 34 +++
 rtl/relm_adc_io.sv | 147 ++++++++++++++
 tb/tb_relm_adc_io.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/relm_adc_io_pkg.sv
// rtl/relm_adc_io_pkg.sv - shared definitions for the ADC128S022 frame sequencer
// Purpose: frame state encoding, ADC frame geometry, result field offsets and
//          the per-bit address helper used by relm_adc_io.
// Ports:   none (package).
package relm_adc_io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_HOLD
    } state_e;

    localparam int ADC_BITS       = 16;
    localparam int ADC_ADDR_LSB   = 2;
    localparam int ADC_DATA_FIRST = 4;
    localparam int SAMPLE_W       = ADC_BITS - ADC_DATA_FIRST;
    localparam int RES_CH_LSB     = 12;
    localparam int RES_SAMPLE_LSB = 0;

    // DIN value for frame bit k: the channel goes out MSB first in bits 2..4,
    // every other bit position is driven low.
    function automatic logic addr_bit(input logic [2:0] ch, input logic [3:0] k);
        case (k)
            4'(ADC_ADDR_LSB):     return ch[2];
            4'(ADC_ADDR_LSB + 1): return ch[1];
            4'(ADC_ADDR_LSB + 2): return ch[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/relm_adc_io_if.sv
// rtl/relm_adc_io_if.sv - ReLM push/pop port bundle for the ADC sequencer
// Purpose: groups the command push port and the result pop port.
// Ports:   cmd_d (push word, [WD] strobe), cmd_retry (push refused),
//          res_d (pop word, [WD] strobe), res_q (result word, [WD] = empty).
//          master = processor side, slave = relm_adc_io side.
interface relm_adc_io_if #(
    parameter int WD = 32
);
    logic [WD:0] cmd_d;
    logic        cmd_retry;
    logic [WD:0] res_d;
    logic [WD:0] res_q;

    modport master (output cmd_d, output res_d, input cmd_retry, input res_q);
    modport slave  (input cmd_d, input res_d, output cmd_retry, output res_q);
endinterface

// File: rtl/relm_adc_io_clkdiv.sv
// rtl/relm_adc_io_clkdiv.sv - SCLK half-period divider
// Purpose: counts DIV clk cycles per phase and flags the last one.
// Ports:   clk, rst (sync, active high), reload_i (restart phase count),
//          phase_end_o (high on the last clk of the current phase).
module relm_adc_io_clkdiv #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic reload_i,
    output logic phase_end_o
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign phase_end_o = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (reload_i || phase_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/relm_adc_io.sv
// rtl/relm_adc_io.sv - SPI frame sequencer for the ADC128S022
// Purpose: each accepted push runs one 16-SCLK frame; the captured sample is
//          held in a one-entry result register until popped.
// Ports:   clk, rst (sync, active high), bus (push/pop ports, slave side),
//          adc_cs_n_out, adc_sclk_out, adc_saddr_out (ADC pins, registered),
//          adc_sdat_in (ADC DOUT, asynchronous).
module relm_adc_io
    import relm_adc_io_pkg::*;
#(
    parameter int WD  = 32,
    parameter int DIV = 8
) (
    input  logic          clk,
    input  logic          rst,
    relm_adc_io_if.slave  bus,
    output logic          adc_cs_n_out,
    output logic          adc_sclk_out,
    output logic          adc_saddr_out,
    input  logic          adc_sdat_in
);
    state_e                state_q;
    logic                  cs_n_q, sclk_q, saddr_q;
    logic                  sync1_q, sync2_q;
    logic [3:0]            bit_q;
    logic [SAMPLE_W-1:0]   shift_q;
    logic [2:0]            new_ch_q, last_ch_q, res_ch_q;
    logic [SAMPLE_W-1:0]   res_sample_q;
    logic                  res_valid_q;

    logic                  cmd_retry;
    logic                  accept;
    logic                  pop;
    logic                  phase_end;
    logic                  reload;
    logic [WD:0]           res_word;
    logic                  unused_bits;

    assign cmd_retry = (state_q != ST_IDLE) | res_valid_q;
    assign accept    = bus.cmd_d[WD] & ~cmd_retry;
    assign pop       = bus.res_d[WD] & res_valid_q;
    // Every state change other than the accept lands on a phase end.
    assign reload    = accept | (phase_end & (state_q != ST_IDLE));

    assign unused_bits = ^{bus.cmd_d[WD-1:3], bus.res_d[WD-1:0]};

    relm_adc_io_clkdiv #(.DIV(DIV)) u_clkdiv (
        .clk         (clk),
        .rst         (rst),
        .reload_i    (reload),
        .phase_end_o (phase_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= adc_sdat_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b1;
            saddr_q      <= 1'b0;
            bit_q        <= '0;
            shift_q      <= '0;
            new_ch_q     <= '0;
            last_ch_q    <= '0;
            res_ch_q     <= '0;
            res_sample_q <= '0;
            res_valid_q  <= 1'b0;
        end else begin
            if (pop) begin
                res_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q  <= ST_SETUP;
                        cs_n_q   <= 1'b0;
                        new_ch_q <= bus.cmd_d[2:0];
                    end
                end
                ST_SETUP: begin
                    if (phase_end) begin
                        state_q <= ST_LOW;
                        sclk_q  <= 1'b0;
                        bit_q   <= '0;
                        saddr_q <= addr_bit(new_ch_q, 4'd0);
                    end
                end
                ST_LOW: begin
                    if (phase_end) begin
                        state_q <= ST_HIGH;
                        sclk_q  <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        // Capture at the very end of the high half-period so
                        // DOUT has had the longest time to settle.
                        shift_q <= {shift_q[SAMPLE_W-2:0], sync2_q};
                        if (bit_q == 4'(ADC_BITS - 1)) begin
                            state_q <= ST_HOLD;
                            cs_n_q  <= 1'b1;
                            saddr_q <= 1'b0;
                        end else begin
                            state_q <= ST_LOW;
                            sclk_q  <= 1'b0;
                            bit_q   <= bit_q + 4'd1;
                            saddr_q <= addr_bit(new_ch_q, bit_q + 4'd1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (phase_end) begin
                        // The ADC converts the address of the previous frame.
                        state_q      <= ST_IDLE;
                        res_ch_q     <= last_ch_q;
                        res_sample_q <= shift_q;
                        res_valid_q  <= 1'b1;
                        last_ch_q    <= new_ch_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        res_word                              = '0;
        res_word[WD]                          = ~res_valid_q;
        res_word[RES_CH_LSB +: 3]             = res_ch_q;
        res_word[RES_SAMPLE_LSB +: SAMPLE_W]  = res_sample_q;
    end

    assign bus.res_q     = res_word;
    assign bus.cmd_retry = cmd_retry;

    assign adc_cs_n_out  = cs_n_q;
    assign adc_sclk_out  = sclk_q;
    assign adc_saddr_out = saddr_q;
endmodule

// File: tb/tb_relm_adc_io.sv
// tb/tb_relm_adc_io.sv - self-checking bench for relm_adc_io (DIV=8 and DIV=2)
module tb_relm_adc_io;
    localparam int WD = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [WD:0] cmd_d [2];
    logic [WD:0] res_d [2];
    logic [WD:0] res_q [2];
    logic [1:0]  retry, cs_n, sclk, saddr;
    logic [15:0] din_a [2];
    int          fcnt_a [2];
    logic [11:0] mem [2][8];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] s;
    } exp_t;
    exp_t sq[$];

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] val;
    } vec_t;
    vec_t tbl[5];

    logic [2:0] dut_last [2];
    logic [2:0] adc_addr [2];

    for (genvar g = 0; g < 2; g++) begin : u
        relm_adc_io_if #(.WD(WD)) bus ();
        logic        sdat_l = 1'b0;
        logic [15:0] din = '0;
        logic [15:0] word;
        logic [2:0]  cur = '0;
        logic        pcs = 1'bx;
        logic        psc = 1'bx;
        int          rise = 0;
        int          fcnt = 0;

        assign bus.cmd_d = cmd_d[g];
        assign bus.res_d = res_d[g];
        assign res_q[g]  = bus.res_q;
        assign retry[g]  = bus.cmd_retry;
        assign din_a[g]  = din;
        assign fcnt_a[g] = fcnt;

        relm_adc_io #(.WD(WD), .DIV(g == 0 ? 8 : 2)) dut (
            .clk           (clk),
            .rst           (rst),
            .bus           (bus.slave),
            .adc_cs_n_out  (cs_n[g]),
            .adc_sclk_out  (sclk[g]),
            .adc_saddr_out (saddr[g]),
            .adc_sdat_in   (sdat_l)
        );

        // ADC model: DIN sampled on SCLK rise, DOUT driven on SCLK fall,
        // address takes effect for the next frame once a full frame is seen.
        always @(cs_n[g], sclk[g]) begin
            if (cs_n[g] === 1'b0 && pcs === 1'b1) begin
                fcnt++;
                rise = 0;
                din  = '0;
            end else if (cs_n[g] === 1'b1 && pcs === 1'b0) begin
                if (rise == 16) cur = din[13:11];
            end else if (cs_n[g] === 1'b0) begin
                if (sclk[g] === 1'b1 && psc === 1'b0 && rise < 16) begin
                    din[4'(15 - rise)] = saddr[g];
                    rise++;
                end
                if (sclk[g] === 1'b0 && psc === 1'b1 && rise < 16) begin
                    word   = {4'h0, mem[g][cur]};
                    sdat_l = word[4'(15 - rise)];
                end
            end
            pcs = cs_n[g];
            psc = sclk[g];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input bit n, input logic [2:0] ch);
        cmd_d[n] = {1'b1, {(WD-3){1'b0}}, ch};
        @(posedge clk);
        @(negedge clk);
        cmd_d[n] = '0;
    endtask

    task automatic wait_result(input bit n, output int lat);
        lat = 0;
        while (res_q[n][WD] !== 1'b0 && lat < 1000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input bit n, input logic [2:0] ch, input int lat);
        exp_t got;
        chk("frame_latency", 32'(lat), 32'(n == 1'b0 ? 272 : 68));
        got = sq.pop_front();
        chk("res_channel", 32'(res_q[n][14:12]), 32'(got.ch));
        chk("res_sample", 32'(res_q[n][11:0]), 32'(got.s));
        chk("res_zero_bits", 32'(res_q[n][WD-1:15]), 32'd0);
        chk("din_address_bits", 32'(din_a[n]), 32'({2'b00, ch, 11'b0}));
        dut_last[n] = ch;
        adc_addr[n] = ch;
    endtask

    task automatic queue_expect(input bit n);
        exp_t e;
        e.ch = dut_last[n];
        e.s  = mem[n][adc_addr[n]];
        sq.push_back(e);
    endtask

    task automatic frame(input bit n, input logic [2:0] ch);
        int lat;
        chk("retry_before_push", 32'(retry[n]), 32'd0);
        queue_expect(n);
        push(n, ch);
        chk("cs_n_low_after_accept", 32'(cs_n[n]), 32'd0);
        wait_result(n, lat);
        check_result(n, ch, lat);
    endtask

    task automatic pop(input bit n);
        res_d[n] = {1'b1, {WD{1'b0}}};
        @(posedge clk);
        @(negedge clk);
        res_d[n] = '0;
        chk("res_empty_after_pop", 32'(res_q[n][WD]), 32'd1);
        chk("retry_after_pop", 32'(retry[n]), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          f0, lat;
        logic [14:0] held;

        for (int i = 0; i < 2; i++) begin
            cmd_d[i]    = '0;
            res_d[i]    = '0;
            dut_last[i] = '0;
            adc_addr[i] = '0;
            for (int j = 0; j < 8; j++) mem[i][j] = '0;
        end

        tbl[0] = '{ch: 3'd5, val: 12'hABC};
        tbl[1] = '{ch: 3'd2, val: 12'h123};
        tbl[2] = '{ch: 3'd7, val: 12'hFFF};
        tbl[3] = '{ch: 3'd0, val: 12'h000};
        tbl[4] = '{ch: 3'd6, val: 12'h5A5};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("reset_cs_n", 32'(cs_n[i]), 32'd1);
            chk("reset_sclk", 32'(sclk[i]), 32'd1);
            chk("reset_saddr", 32'(saddr[i]), 32'd0);
            chk("reset_retry", 32'(retry[i]), 32'd0);
            chk("reset_res_empty", 32'(res_q[i][WD]), 32'd1);
        end

        for (int i = 0; i < 5; i++) begin
            mem[0][adc_addr[0]] = tbl[i].val;
            frame(1'b0, tbl[i].ch);
            pop(1'b0);
            if (i == 1) begin
                held = res_q[0][14:0];
                f0   = fcnt_a[0];
                pop(1'b0);
                chk("second_pop_data_stable", 32'(res_q[0][14:0]), 32'(held));
                chk("second_pop_no_frame", 32'(fcnt_a[0] - f0), 32'd0);
            end
        end

        // Strobes held during the frame and while the result sits unread.
        mem[0][adc_addr[0]] = 12'h3C3;
        f0 = fcnt_a[0];
        queue_expect(1'b0);
        push(1'b0, 3'd4);
        cmd_d[0] = {1'b1, {(WD-3){1'b0}}, 3'd6};
        chk("retry_during_frame", 32'(retry[0]), 32'd1);
        wait_result(1'b0, lat);
        lat = lat + 0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("retry_result_unread", 32'(retry[0]), 32'd1);
        chk("single_cs_window", 32'(fcnt_a[0] - f0), 32'd1);
        chk("cs_n_high_while_unread", 32'(cs_n[0]), 32'd1);
        cmd_d[0] = '0;
        check_result(1'b0, 3'd4, lat);
        pop(1'b0);

        // Reset in the middle of bit 7.
        push(1'b0, 3'd1);
        repeat (120) @(posedge clk);
        @(negedge clk);
        chk("mid_frame_sclk_low", 32'(sclk[0]), 32'd0);
        chk("mid_frame_cs_n_low", 32'(cs_n[0]), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_cs_n", 32'(cs_n[0]), 32'd1);
        chk("abort_sclk", 32'(sclk[0]), 32'd1);
        chk("abort_saddr", 32'(saddr[0]), 32'd0);
        chk("abort_idle_retry", 32'(retry[0]), 32'd0);
        chk("abort_res_empty", 32'(res_q[0][WD]), 32'd1);
        dut_last[0] = 3'd0;
        mem[0][adc_addr[0]] = 12'h7E1;
        frame(1'b0, 3'd3);
        pop(1'b0);

        for (int i = 0; i < 100; i++) begin
            mem[1][adc_addr[1]] = 12'($urandom);
            frame(1'b1, 3'($urandom_range(0, 7)));
            pop(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
